// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared constants for the display-conversion path: operand and
// result widths, arbiter FSM encodings and a one-hot helper.
package bcd_conv_arbiter_pkg;

    localparam int BIN_W   = 8;
    localparam int BCD_W   = 12;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Sized for the largest legal requester count; callers truncate.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_bin2bcd.sv
// Combinational 8-bit binary to 3-digit BCD converter (double dabble).
// Ports: binary (8-bit in), BCD (12-bit out, hundreds/tens/units).
module bcd_conv_arbiter_bin2bcd
    import bcd_conv_arbiter_pkg::*;
(
    input  logic [BIN_W-1:0] binary,
    output logic [BCD_W-1:0] BCD
);

    always_comb begin : dabble
        logic [BIN_W+BCD_W-1:0] s;
        s = {{BCD_W{1'b0}}, binary};
        for (int i = 0; i < BIN_W; i++) begin
            // Adjust any digit >= 5 before the shift doubles it.
            if (s[BIN_W+3:BIN_W] >= 4'd5)
                s[BIN_W+3:BIN_W] = s[BIN_W+3:BIN_W] + 4'd3;
            if (s[BIN_W+7:BIN_W+4] >= 4'd5)
                s[BIN_W+7:BIN_W+4] = s[BIN_W+7:BIN_W+4] + 4'd3;
            if (s[BIN_W+11:BIN_W+8] >= 4'd5)
                s[BIN_W+11:BIN_W+8] = s[BIN_W+11:BIN_W+8] + 4'd3;
            s = s << 1;
        end
        BCD = s[BIN_W+BCD_W-1:BIN_W];
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one bin2bcd between NUM_REQ requesters.
// Ports: clk, rst (async high); req/bin per requester in; ack one-hot
// pulse on capture; busy; done/done_tag/done_bcd on result write;
// bcd_hold holds the latest result per requester.
module bcd_conv_arbiter
    import bcd_conv_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*BIN_W-1:0] bin,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     busy,
    output logic                     done,
    output logic [TAG_W-1:0]         done_tag,
    output logic [BCD_W-1:0]         done_bcd,
    output logic [NUM_REQ*BCD_W-1:0] bcd_hold
);

    state_t             state_q;
    state_t             state_d;
    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   tag_reg;
    logic [BIN_W-1:0]   op_reg;
    logic [TAG_W-1:0]   win;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   done_bcd_q;
    logic [TAG_W-1:0]   done_tag_q;
    logic               capture;
    logic               commit;
    logic [BIN_W-1:0]   bin_arr [NUM_REQ];
    logic [BCD_W-1:0]   hold_q  [NUM_REQ];

    // (p + n) mod NUM_REQ; p < NUM_REQ and n < NUM_REQ, so one
    // conditional subtract is enough.
    function automatic logic [TAG_W-1:0] wrap_add(
        input logic [TAG_W-1:0] p,
        input logic [TAG_W:0]   n
    );
        logic [TAG_W:0] s;
        s = {1'b0, p} + n;
        if (s >= (TAG_W+1)'(NUM_REQ))
            s = s - (TAG_W+1)'(NUM_REQ);
        return s[TAG_W-1:0];
    endfunction

    // Rotate req so rr_ptr sits at bit 0, take the lowest set bit,
    // then rotate the offset back into a requester index.
    function automatic logic [TAG_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [TAG_W-1:0]   p
    );
        logic [NUM_REQ-1:0] rot;
        logic [TAG_W:0]     off;
        logic               found;
        rot   = NUM_REQ'({r, r} >> p);
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                off   = (TAG_W+1)'(i);
                found = 1'b1;
            end
        end
        return wrap_add(p, off);
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++)
            bin_arr[k] = bin[k*BIN_W +: BIN_W];
    end

    assign win = rr_pick(req, rr_ptr);

    bcd_conv_arbiter_bin2bcd u_bin2bcd (
        .binary (op_reg),
        .BCD    (bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req) state_d = CONV;
            CONV:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ack/done/busy decode straight from state so an async reset
    // drops them in the same cycle.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        capture = (state_q == IDLE) && (|req);
        commit  = (state_q == CONV);
        ack     = '0;
        if (state_q == CONV)
            ack = NUM_REQ'(onehot(3'(tag_reg)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            tag_reg    <= '0;
            op_reg     <= '0;
            done_bcd_q <= '0;
            done_tag_q <= '0;
            for (int k = 0; k < NUM_REQ; k++)
                hold_q[k] <= '0;
        end else begin
            if (capture) begin
                op_reg  <= bin_arr[win];
                tag_reg <= win;
            end
            if (commit) begin
                done_bcd_q      <= bcd;
                done_tag_q      <= tag_reg;
                hold_q[tag_reg] <= bcd;
                rr_ptr          <= wrap_add(tag_reg, (TAG_W+1)'(1));
            end
        end
    end

    assign done_bcd = done_bcd_q;
    assign done_tag = done_tag_q;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++)
            bcd_hold[k*BCD_W +: BCD_W] = hold_q[k];
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter (NUM_REQ=3):
// table of single-requester conversions plus arbitration sequences.
module tb_bcd_conv_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] bin;
    logic [2:0]  ack;
    logic        busy;
    logic        done;
    logic [1:0]  done_tag;
    logic [11:0] done_bcd;
    logic [35:0] bcd_hold;
    logic [11:0] hv [3];

    int checks;
    int failures;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] bin;
        logic [1:0]  tag;
        logic [11:0] bcd;
    } vec_t;

    vec_t        vecs [6];
    logic [11:0] exp_hold [3];

    bcd_conv_arbiter #(.NUM_REQ(3), .TAG_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .bin      (bin),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .done_tag (done_tag),
        .done_bcd (done_bcd),
        .bcd_hold (bcd_hold)
    );

    assign hv[0] = bcd_hold[11:0];
    assign hv[1] = bcd_hold[23:12];
    assign hv[2] = bcd_hold[35:24];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_holds(input string name);
        for (int k = 0; k < 3; k++)
            chk(name, 64'(hv[k]), 64'(exp_hold[k]));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        req = '0;
        bin = '0;
        for (int k = 0; k < 3; k++)
            exp_hold[k] = '0;

        vecs[0] = '{3'b001, {8'd0,   8'd0,   8'd137}, 2'd0, 12'h137};
        vecs[1] = '{3'b010, {8'd0,   8'd0,   8'd0},   2'd1, 12'h000};
        vecs[2] = '{3'b100, {8'd255, 8'd0,   8'd0},   2'd2, 12'h255};
        vecs[3] = '{3'b010, {8'd0,   8'd99,  8'd0},   2'd1, 12'h099};
        vecs[4] = '{3'b001, {8'd0,   8'd0,   8'd10},  2'd0, 12'h010};
        vecs[5] = '{3'b100, {8'd58,  8'd0,   8'd0},   2'd2, 12'h058};

        step();
        step();
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_tag", 64'(done_tag), 64'd0);
        chk("rst_bcd", 64'(done_bcd), 64'd0);
        chk("rst_hold", 64'(bcd_hold), 64'd0);
        rst = 1'b0;
        step();

        // Single-requester table
        for (int v = 0; v < 6; v++) begin
            req = vecs[v].req;
            bin = vecs[v].bin;
            step();
            chk("tbl_ack", 64'(ack), 64'(3'b001 << vecs[v].tag));
            chk("tbl_busy", 64'(busy), 64'd1);
            chk("tbl_done0", 64'(done), 64'd0);
            req = '0;
            step();
            chk("tbl_done", 64'(done), 64'd1);
            chk("tbl_ack0", 64'(ack), 64'd0);
            chk("tbl_tag", 64'(done_tag), 64'(vecs[v].tag));
            chk("tbl_bcd", 64'(done_bcd), 64'(vecs[v].bcd));
            exp_hold[vecs[v].tag] = vecs[v].bcd;
            chk_holds("tbl_hold");
            step();
            chk("tbl_idle_busy", 64'(busy), 64'd0);
            chk("tbl_idle_done", 64'(done), 64'd0);
        end

        // Fresh reset, then all three requesters at once
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++)
            exp_hold[k] = '0;
        req = 3'b111;
        bin = {8'd255, 8'd99, 8'd0};
        step();
        chk("all_ack0", 64'(ack), 64'b001);
        req = 3'b110;
        step();
        chk("all_tag0", 64'(done_tag), 64'd0);
        chk("all_bcd0", 64'(done_bcd), 64'h000);
        step();
        chk("all_gap_busy", 64'(busy), 64'd0);
        step();
        chk("all_ack1", 64'(ack), 64'b010);
        req = 3'b100;
        step();
        chk("all_tag1", 64'(done_tag), 64'd1);
        chk("all_bcd1", 64'(done_bcd), 64'h099);
        step();
        step();
        chk("all_ack2", 64'(ack), 64'b100);
        req = 3'b000;
        step();
        chk("all_tag2", 64'(done_tag), 64'd2);
        chk("all_bcd2", 64'(done_bcd), 64'h255);
        chk("all_hold", 64'(bcd_hold), 64'({12'h255, 12'h099, 12'h000}));
        step();

        // Fairness: after 1 wins, 2 is ahead of 0
        req = 3'b010;
        bin = {8'd2, 8'd77, 8'd1};
        step();
        chk("fair_ack1", 64'(ack), 64'b010);
        req = 3'b101;
        step();
        chk("fair_bcd1", 64'(done_bcd), 64'h077);
        step();
        step();
        chk("fair_ack2", 64'(ack), 64'b100);
        req = 3'b001;
        step();
        chk("fair_tag2", 64'(done_tag), 64'd2);
        chk("fair_bcd2", 64'(done_bcd), 64'h002);
        step();
        step();
        chk("fair_ack0", 64'(ack), 64'b001);
        req = 3'b000;
        step();
        chk("fair_tag0", 64'(done_tag), 64'd0);
        chk("fair_bcd0", 64'(done_bcd), 64'h001);
        step();

        // Held request repeats every 3 cycles
        req = 3'b010;
        bin = {8'd0, 8'd42, 8'd0};
        for (int c = 1; c <= 9; c++) begin
            step();
            chk("hold_ack", 64'(ack), (c % 3 == 1) ? 64'b010 : 64'd0);
            chk("hold_done", 64'(done), (c % 3 == 2) ? 64'd1 : 64'd0);
            if (c % 3 == 2)
                chk("hold_bcd", 64'(done_bcd), 64'h042);
        end
        req = 3'b000;
        step();

        // Operand change after capture is ignored
        req = 3'b001;
        bin = {8'd0, 8'd0, 8'd200};
        step();
        chk("cap_ack", 64'(ack), 64'b001);
        bin = {8'd0, 8'd0, 8'd7};
        req = 3'b000;
        step();
        chk("cap_bcd", 64'(done_bcd), 64'h200);
        chk("cap_hold0", 64'(hv[0]), 64'h200);
        step();

        // Reset during CONV
        req = 3'b100;
        bin = {8'd5, 8'd0, 8'd0};
        step();
        chk("mid_ack_pre", 64'(ack), 64'b100);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_ack", 64'(ack), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_hold", 64'(bcd_hold), 64'd0);
        req = 3'b000;
        step();
        chk("mid_done_r", 64'(done), 64'd0);
        rst = 1'b0;
        step();
        chk("mid_done_after", 64'(done), 64'd0);
        chk("mid_busy_after", 64'(busy), 64'd0);
        chk("mid_hold2", 64'(hv[2]), 64'd0);
        req = 3'b101;
        bin = {8'd4, 8'd0, 8'd3};
        step();
        chk("post_ack0", 64'(ack), 64'b001);
        req = 3'b100;
        step();
        chk("post_tag0", 64'(done_tag), 64'd0);
        chk("post_bcd0", 64'(done_bcd), 64'h003);
        step();
        step();
        chk("post_ack2", 64'(ack), 64'b100);
        req = 3'b000;
        step();
        chk("post_tag2", 64'(done_tag), 64'd2);
        chk("post_bcd2", 64'(done_bcd), 64'h004);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
